// File: rtl/wb_checker.sv
// Register-file write checker: compares CPU register writes against a preloaded
// table of expected {reg, data} entries and reports pass, mismatch or timeout.
module wb_checker #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_idx,
    input  logic [RADDR_W-1:0]         ld_reg,
    input  logic [XLEN-1:0]            ld_data,
    input  logic [$clog2(DEPTH):0]     ld_count,
    input  logic                       start,
    input  logic                       reg_write,
    input  logic [RADDR_W-1:0]         write_reg,
    input  logic [XLEN-1:0]            write_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH)-1:0]   err_idx,
    output logic [XLEN-1:0]            got_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t              state, state_nxt;
    logic [RADDR_W-1:0]  exp_reg_tbl  [DEPTH];
    logic [XLEN-1:0]     exp_data_tbl [DEPTH];
    logic [IW-1:0]       ptr;
    logic [TW-1:0]       idle_cnt;
    logic [IW:0]         cnt_lat;
    logic [IW:0]         cnt_eff;
    logic                accept, reg_mis, data_mis, match, last, timeout_hit, go;

    // Compare path: an x0 write is invisible to the checker.
    always_comb begin
        accept      = (state == S_RUN) && reg_write && (write_reg != '0);
        reg_mis     = accept && (write_reg != exp_reg_tbl[ptr]);
        data_mis    = accept && !reg_mis && (write_data != exp_data_tbl[ptr]);
        match       = accept && !reg_mis && !data_mis;
        last        = ({1'b0, ptr} == (cnt_lat - 1'b1));
        timeout_hit = (state == S_RUN) && !accept && (idle_cnt == TW'(TIMEOUT - 1));
        go          = start && (state != S_RUN);
        cnt_eff     = ((ld_count == '0) || (ld_count > (IW+1)'(DEPTH))) ? (IW+1)'(DEPTH) : ld_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (reg_mis || data_mis)  state_nxt = S_FAIL;
                else if (match && last)   state_nxt = S_PASS;
                else if (timeout_hit)     state_nxt = S_FAIL;
            end
            S_PASS:  if (start) state_nxt = S_RUN;
            S_FAIL:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_PASS) || (state == S_FAIL);
        pass = (state == S_PASS);
    end

    // Expected-write table survives reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (ld_en && (state == S_IDLE)) begin
            exp_reg_tbl[ld_idx]  <= ld_reg;
            exp_data_tbl[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            idle_cnt  <= '0;
            cnt_lat   <= '0;
            fail_code <= 2'd0;
            err_idx   <= '0;
            got_data  <= '0;
        end else if (go) begin
            ptr       <= '0;
            idle_cnt  <= '0;
            cnt_lat   <= cnt_eff;
            fail_code <= 2'd0;
            err_idx   <= '0;
            got_data  <= '0;
        end else if (state == S_RUN) begin
            if (reg_mis || data_mis) begin
                fail_code <= reg_mis ? 2'd2 : 2'd1;
                err_idx   <= ptr;
                got_data  <= write_data;
            end else if (match) begin
                idle_cnt <= '0;
                if (!last) ptr <= ptr + 1'b1;
            end else if (timeout_hit) begin
                fail_code <= 2'd3;
                err_idx   <= ptr;
                got_data  <= '0;
                idle_cnt  <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_checker.sv
// Directed bench for wb_checker: pass, data/register mismatch, timeout,
// async abort, write-beats-timeout and short/locked-table cases.
module tb_wb_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic [4:0]  ld_count;
    logic        start;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [3:0]  err_idx;
    logic [31:0] got_data;

    int n_cmp = 0;
    int n_err = 0;

    wb_checker #(.XLEN(32), .RADDR_W(5), .DEPTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_reg(ld_reg),
        .ld_data(ld_data), .ld_count(ld_count), .start(start),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .err_idx(err_idx), .got_data(got_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] idx, input logic [4:0] r, input logic [31:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_reg = r; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] cnt);
        ld_count = cnt; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        reg_write = 1'b1; write_reg = r; write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic b, input logic dn, input logic p,
                           input logic [1:0] fc, input logic [3:0] ei, input logic [31:0] gd);
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".pass"}, 64'(pass), 64'(p));
        chk({tag, ".fail_code"}, 64'(fail_code), 64'(fc));
        chk({tag, ".err_idx"}, 64'(err_idx), 64'(ei));
        chk({tag, ".got_data"}, 64'(got_data), 64'(gd));
    endtask

    initial begin
        rst = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_reg = '0; ld_data = '0;
        ld_count = '0; start = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        #3;
        verdict("reset", 0, 0, 0, 2'd0, 4'd0, 32'd0);
        #10 rst = 1'b1;
        tick();

        // table {x4=1, x5=1, x4=0}
        load(4'd0, 5'd4, 32'd1);
        load(4'd1, 5'd5, 32'd1);
        load(4'd2, 5'd4, 32'd0);

        go(5'd3);
        verdict("start", 1, 0, 0, 2'd0, 4'd0, 32'd0);
        wr(5'd4, 32'd1);
        wr(5'd5, 32'd1);
        chk("pass.mid_busy", 64'(busy), 64'd1);
        wr(5'd4, 32'd0);
        verdict("pass", 0, 1, 1, 2'd0, 4'd0, 32'd0);
        wr(5'd7, 32'h5);
        verdict("pass_hold", 0, 1, 1, 2'd0, 4'd0, 32'd0);

        go(5'd3);
        wr(5'd4, 32'd1);
        wr(5'd5, 32'd1);
        wr(5'd4, 32'h1);
        verdict("data_mis", 0, 1, 0, 2'd1, 4'd2, 32'h1);

        // register and data both wrong: register mismatch is reported
        go(5'd3);
        wr(5'd6, 32'h55);
        verdict("reg_mis", 0, 1, 0, 2'd2, 4'd0, 32'h55);

        // timeout with interleaved x0 writes on RUN cycles 2 and 4
        go(5'd3);
        tick();
        wr(5'd0, 32'hdead);
        tick();
        wr(5'd0, 32'hbeef);
        tick(); tick(); tick();
        chk("tmo.before_busy", 64'(busy), 64'd1);
        chk("tmo.before_done", 64'(done), 64'd0);
        tick();
        verdict("timeout", 0, 1, 0, 2'd3, 4'd0, 32'd0);

        // async abort after one match
        go(5'd3);
        wr(5'd4, 32'd1);
        #2 rst = 1'b0;
        #1;
        verdict("abort", 0, 0, 0, 2'd0, 4'd0, 32'd0);
        rst = 1'b1;
        tick();
        go(5'd3);
        wr(5'd4, 32'd1);
        wr(5'd5, 32'd1);
        wr(5'd4, 32'd0);
        verdict("rerun", 0, 1, 1, 2'd0, 4'd0, 32'd0);

        // accepted write on the cycle the idle counter would expire
        go(5'd3);
        repeat (7) tick();
        wr(5'd4, 32'd1);
        chk("race1.busy", 64'(busy), 64'd1);
        chk("race1.done", 64'(done), 64'd0);
        repeat (7) tick();
        wr(5'd5, 32'd1);
        chk("race2.busy", 64'(busy), 64'd1);
        wr(5'd4, 32'd0);
        verdict("race_pass", 0, 1, 1, 2'd0, 4'd0, 32'd0);

        // loads in PASS are ignored; count 1 passes on the first write
        load(4'd0, 5'd9, 32'h9);
        go(5'd1);
        wr(5'd4, 32'd1);
        verdict("cnt1", 0, 1, 1, 2'd0, 4'd0, 32'd0);

        // count 0 means DEPTH: three matches leave the run busy
        go(5'd0);
        wr(5'd4, 32'd1);
        wr(5'd5, 32'd1);
        wr(5'd4, 32'd0);
        chk("cnt0.busy", 64'(busy), 64'd1);
        chk("cnt0.done", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
